// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - VGA mode constants and timing helpers
package vga_pkg;

  // 800x600@60 Hz on a 40 MHz pixel clock
  localparam int SVGA_H_SYNC   = 128;
  localparam int SVGA_H_BACK   = 88;
  localparam int SVGA_H_ACTIVE = 800;
  localparam int SVGA_H_FRONT  = 40;
  localparam int SVGA_V_SYNC   = 4;
  localparam int SVGA_V_BACK   = 23;
  localparam int SVGA_V_ACTIVE = 600;
  localparam int SVGA_V_FRONT  = 1;

  // 640x480@60 Hz
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_H_ACTIVE  = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
  localparam int VGA_V_ACTIVE  = 480;
  localparam int VGA_V_FRONT   = 10;

  function automatic int total(input int sync_w, input int back_w,
                               input int active_w, input int front_w);
    return sync_w + back_w + active_w + front_w;
  endfunction

endpackage

// File: rtl/vga_span_cnt.sv
// rtl/vga_span_cnt.sv - wrapping span counter with enable, sync clear and carry
module vga_span_cnt #(
  parameter int TOT = 4,
  parameter int W   = 2
) (
  input  logic         CLK_40M,
  input  logic         SYS_RST,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         carry
);

  localparam logic [W-1:0] LAST = W'(TOT - 1);

  assign carry = en && (cnt == LAST);

  always_ff @(posedge CLK_40M or posedge SYS_RST) begin
    if (SYS_RST) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= carry ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen_p.sv
// rtl/vga_timing_gen_p.sv - parametrised VGA raster timing generator with 2-stage output pipeline
module vga_timing_gen_p
  import vga_pkg::*;
#(
  parameter int H_SYNC   = SVGA_H_SYNC,
  parameter int H_BACK   = SVGA_H_BACK,
  parameter int H_ACTIVE = SVGA_H_ACTIVE,
  parameter int H_FRONT  = SVGA_H_FRONT,
  parameter int V_SYNC   = SVGA_V_SYNC,
  parameter int V_BACK   = SVGA_V_BACK,
  parameter int V_ACTIVE = SVGA_V_ACTIVE,
  parameter int V_FRONT  = SVGA_V_FRONT,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int IN_W     = 16,
  parameter int DATA_W   = 9,
  parameter int REQ_LEAD = 4,
  parameter logic [DATA_W-1:0] UND_COLOR = '0,
  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1
) (
  input  logic              CLK_40M,
  input  logic              SYS_RST,
  input  logic              EN,
  input  logic [IN_W-1:0]   SRC_DATA,
  input  logic              SRC_VALID,
  input  logic              UND_CLR,
  output logic [DATA_W-1:0] VGA_DATA,
  output logic              VGA_DE,
  output logic              VGA_HSYNC,
  output logic              VGA_VSYNC,
  output logic              VGA_REQ,
  output logic [YW-1:0]     REQ_LINE,
  output logic [XW-1:0]     PIX_X,
  output logic [YW-1:0]     PIX_Y,
  output logic              FRAME_START,
  output logic              UNDERFLOW
);

  localparam int H_TOT = total(H_SYNC, H_BACK, H_ACTIVE, H_FRONT);
  localparam int V_TOT = total(V_SYNC, V_BACK, V_ACTIVE, V_FRONT);
  localparam int HW    = (H_TOT > 1) ? $clog2(H_TOT) : 1;
  localparam int VW    = (V_TOT > 1) ? $clog2(V_TOT) : 1;

  localparam logic [31:0] H_SYNC_E = 32'(H_SYNC);
  localparam logic [31:0] V_SYNC_E = 32'(V_SYNC);
  localparam logic [31:0] H_ST     = 32'(H_SYNC + H_BACK);
  localparam logic [31:0] H_END    = 32'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [31:0] V_ST     = 32'(V_SYNC + V_BACK);
  localparam logic [31:0] V_END    = 32'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [31:0] REQ_H    = 32'(H_SYNC + H_BACK - REQ_LEAD);

  if (REQ_LEAD < 1 || REQ_LEAD > H_SYNC + H_BACK) begin : g_bad_lead
    $error("REQ_LEAD must lie in 1..H_SYNC+H_BACK");
  end
  if (DATA_W > IN_W) begin : g_bad_width
    $error("DATA_W must not exceed IN_W");
  end
  if (IN_W > DATA_W) begin : g_src_hi
    logic src_hi_unused;
    assign src_hi_unused = ^SRC_DATA[IN_W-1:DATA_W];
  end

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          h_carry;
  logic          v_wrap_unused;

  vga_span_cnt #(.TOT(H_TOT), .W(HW)) u_hcnt (
    .CLK_40M (CLK_40M), .SYS_RST (SYS_RST), .en (EN), .clr (!EN),
    .cnt (hcnt), .carry (h_carry)
  );

  vga_span_cnt #(.TOT(V_TOT), .W(VW)) u_vcnt (
    .CLK_40M (CLK_40M), .SYS_RST (SYS_RST), .en (EN && h_carry), .clr (!EN),
    .cnt (vcnt), .carry (v_wrap_unused)
  );

  // Decode on zero-extended counters so region bounds never wrap
  logic [31:0] hc, vc;
  logic        h_act, v_act, act, req_hit;

  assign hc      = 32'(hcnt);
  assign vc      = 32'(vcnt);
  assign h_act   = (hc >= H_ST) && (hc < H_END);
  assign v_act   = (vc >= V_ST) && (vc < V_END);
  assign act     = EN && h_act && v_act;
  assign req_hit = EN && v_act && (hc == REQ_H);

  logic              s1_hs, s1_vs, s1_de, s1_und, s1_fs;
  logic [DATA_W-1:0] s1_data;
  logic [XW-1:0]     s1_x;
  logic [YW-1:0]     s1_y;

  always_ff @(posedge CLK_40M or posedge SYS_RST) begin
    if (SYS_RST) begin
      s1_hs       <= 1'b0;
      s1_vs       <= 1'b0;
      s1_de       <= 1'b0;
      s1_und      <= 1'b0;
      s1_fs       <= 1'b0;
      s1_data     <= '0;
      s1_x        <= '0;
      s1_y        <= '0;
      VGA_HSYNC   <= ~HS_POL;
      VGA_VSYNC   <= ~VS_POL;
      VGA_DE      <= 1'b0;
      VGA_DATA    <= '0;
      PIX_X       <= '0;
      PIX_Y       <= '0;
      FRAME_START <= 1'b0;
      UNDERFLOW   <= 1'b0;
      VGA_REQ     <= 1'b0;
      REQ_LINE    <= '0;
    end else begin
      s1_hs   <= EN && (hc < H_SYNC_E);
      s1_vs   <= EN && (vc < V_SYNC_E);
      s1_de   <= act;
      s1_und  <= act && !SRC_VALID;
      s1_fs   <= EN && (hcnt == '0) && (vcnt == '0);
      s1_data <= !act ? '0 : (SRC_VALID ? SRC_DATA[DATA_W-1:0] : UND_COLOR);
      s1_x    <= act ? XW'(hc - H_ST) : '0;
      s1_y    <= act ? YW'(vc - V_ST) : '0;

      VGA_HSYNC   <= s1_hs ? HS_POL : ~HS_POL;
      VGA_VSYNC   <= s1_vs ? VS_POL : ~VS_POL;
      VGA_DE      <= s1_de;
      VGA_DATA    <= s1_data;
      PIX_X       <= s1_x;
      PIX_Y       <= s1_y;
      FRAME_START <= s1_fs;
      // A new underflow in the same clock as a clear keeps the flag set
      UNDERFLOW   <= s1_und | (UNDERFLOW & ~UND_CLR);

      VGA_REQ <= req_hit;
      if (req_hit) begin
        REQ_LINE <= YW'(vc - V_ST);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen_p.sv
// tb/tb_vga_timing_gen_p.sv - randomized self-checking bench for vga_timing_gen_p on a small mode
module tb_vga_timing_gen_p;

  localparam int HS = 5, HB = 6, HA = 20, HF = 3;
  localparam int VS = 2, VB = 3, VA = 10, VF = 2;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int LEAD = 4;
  localparam bit HSP = 1'b0;
  localparam bit VSP = 1'b1;
  localparam logic [8:0] UND = 9'h1A5;
  localparam logic [27:0] RST_VEC = {~HSP, ~VSP, 26'd0};

  logic        CLK_40M = 1'b0;
  logic        SYS_RST, EN, SRC_VALID, UND_CLR;
  logic [15:0] SRC_DATA;
  logic [8:0]  VGA_DATA;
  logic        VGA_DE, VGA_HSYNC, VGA_VSYNC, VGA_REQ, FRAME_START, UNDERFLOW;
  logic [3:0]  REQ_LINE, PIX_Y;
  logic [4:0]  PIX_X;

  always #5 CLK_40M = ~CLK_40M;

  vga_timing_gen_p #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
    .HS_POL(HSP), .VS_POL(VSP), .IN_W(16), .DATA_W(9),
    .REQ_LEAD(LEAD), .UND_COLOR(UND)
  ) dut (
    .CLK_40M(CLK_40M), .SYS_RST(SYS_RST), .EN(EN), .SRC_DATA(SRC_DATA),
    .SRC_VALID(SRC_VALID), .UND_CLR(UND_CLR), .VGA_DATA(VGA_DATA), .VGA_DE(VGA_DE),
    .VGA_HSYNC(VGA_HSYNC), .VGA_VSYNC(VGA_VSYNC), .VGA_REQ(VGA_REQ), .REQ_LINE(REQ_LINE),
    .PIX_X(PIX_X), .PIX_Y(PIX_Y), .FRAME_START(FRAME_START), .UNDERFLOW(UNDERFLOW)
  );

  typedef struct packed {
    logic       hs, vs, de;
    logic [8:0] data;
    logic       fs, und, req;
    logic [4:0] x;
    logic [3:0] y;
    logic [3:0] rl;
  } rec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          p;
  rec_t        s1_m, out_m, req_m;
  logic        und_m;
  logic [27:0] exp_vec, dut_vec;

  // Expected raster content for absolute position pos since the frame restart
  function automatic rec_t model(input int pos, input logic en, input logic [15:0] d, input logic v);
    rec_t r;
    int   h, ln;
    r  = '0;
    h  = pos % HT;
    ln = (pos / HT) % VT;
    if (en) begin
      r.hs = (h < HS);
      r.vs = (ln < VS);
      r.fs = (h == 0) && (ln == 0);
      r.de = (h >= HS + HB) && (h < HS + HB + HA) && (ln >= VS + VB) && (ln < VS + VB + VA);
      if (r.de) begin
        r.data = v ? d[8:0] : UND;
        r.und  = !v;
        r.x    = 5'(h - (HS + HB));
        r.y    = 4'(ln - (VS + VB));
      end
      r.req = (h == HS + HB - LEAD) && (ln >= VS + VB) && (ln < VS + VB + VA);
      r.rl  = 4'(ln - (VS + VB));
    end
    return r;
  endfunction

  function automatic logic [27:0] build_exp();
    return {out_m.hs ? HSP : ~HSP, out_m.vs ? VSP : ~VSP, out_m.de, out_m.data,
            req_m.req, out_m.fs, und_m, out_m.de ? out_m.x : 5'd0,
            out_m.de ? out_m.y : 4'd0, req_m.req ? req_m.rl : 4'd0};
  endfunction

  function automatic logic [27:0] get_dut();
    return {VGA_HSYNC, VGA_VSYNC, VGA_DE, VGA_DATA, VGA_REQ, FRAME_START, UNDERFLOW,
            VGA_DE ? PIX_X : 5'd0, VGA_DE ? PIX_Y : 4'd0, VGA_REQ ? REQ_LINE : 4'd0};
  endfunction

  task automatic model_reset();
    p = 0; s1_m = '0; out_m = '0; req_m = '0; und_m = 1'b0;
    exp_vec = build_exp();
  endtask

  // One clock: advance the reference, sample the DUT 1 ns after the edge, new random pixel
  task automatic tick();
    rec_t r;
    logic en_s, und_n;
    r     = model(p, EN, SRC_DATA, SRC_VALID);
    en_s  = EN;
    und_n = s1_m.und | (und_m & ~UND_CLR);
    @(posedge CLK_40M);
    out_m = s1_m; s1_m = r; req_m = r; und_m = und_n;
    p = en_s ? p + 1 : 0;
    #1;
    exp_vec  = build_exp();
    dut_vec  = get_dut();
    SRC_DATA = 16'($urandom);
  endtask

  task automatic do_reset();
    @(negedge CLK_40M); SYS_RST = 1'b1;
    @(posedge CLK_40M);
    @(negedge CLK_40M); SYS_RST = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (get_dut() !== RST_VEC) begin
      n_fail++; $display("FAIL reset_async got=%h exp=%h", get_dut(), RST_VEC);
    end
    @(posedge CLK_40M); @(posedge CLK_40M); #1;
    n_checks++;
    if (get_dut() !== RST_VEC) begin
      n_fail++; $display("FAIL reset_held got=%h exp=%h", get_dut(), RST_VEC);
    end
    @(negedge CLK_40M); SYS_RST = 1'b0;
    model_reset();
  endtask

  task automatic test_frame_counts();
    int hs_c = 0, vs_c = 0, de_c = 0, rq_c = 0, fs_c = 0, first_t = 0;
    logic [3:0] first_rl = '1, last_rl = '0;
    EN = 1'b1; SRC_VALID = 1'b1; UND_CLR = 1'b0;
    for (int i = 1; i <= HT * VT + 1; i++) begin
      tick();
      n_checks++;
      if (dut_vec !== exp_vec) begin
        n_fail++; $display("FAIL frame tick=%0d got=%h exp=%h", i, dut_vec, exp_vec);
      end
      if (i >= 2) begin
        hs_c += (VGA_HSYNC == HSP) ? 1 : 0;
        vs_c += (VGA_VSYNC == VSP) ? 1 : 0;
      end
      de_c += VGA_DE ? 1 : 0;
      fs_c += FRAME_START ? 1 : 0;
      if (VGA_REQ) begin
        rq_c++;
        if (first_t == 0) begin first_t = i; first_rl = REQ_LINE; end
        last_rl = REQ_LINE;
      end
    end
    n_checks++; if (hs_c !== HS * VT) begin n_fail++; $display("FAIL hsync_clocks got=%0d exp=%0d", hs_c, HS * VT); end
    n_checks++; if (vs_c !== VS * HT) begin n_fail++; $display("FAIL vsync_clocks got=%0d exp=%0d", vs_c, VS * HT); end
    n_checks++; if (de_c !== HA * VA) begin n_fail++; $display("FAIL de_clocks got=%0d exp=%0d", de_c, HA * VA); end
    n_checks++; if (rq_c !== VA) begin n_fail++; $display("FAIL req_count got=%0d exp=%0d", rq_c, VA); end
    n_checks++; if (fs_c !== 1) begin n_fail++; $display("FAIL frame_start_count got=%0d exp=1", fs_c); end
    n_checks++;
    if (first_t !== (VS + VB) * HT + (HS + HB - LEAD) + 1) begin
      n_fail++; $display("FAIL first_req_tick got=%0d exp=%0d", first_t, (VS + VB) * HT + (HS + HB - LEAD) + 1);
    end
    n_checks++; if (first_rl !== 4'd0) begin n_fail++; $display("FAIL first_req_line got=%0d exp=0", first_rl); end
    n_checks++; if (last_rl !== 4'(VA - 1)) begin n_fail++; $display("FAIL last_req_line got=%0d exp=%0d", last_rl, VA - 1); end
  endtask

  task automatic test_underflow();
    int target;
    target = (VS + VB) * HT + HS + HB + 5;
    do_reset();
    SRC_VALID = 1'b1; UND_CLR = 1'b0;
    for (int k = 0; k < 2 * HT * VT && p != target; k++) begin
      tick();
      n_checks++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL und_lead p=%0d got=%h exp=%h", p, dut_vec, exp_vec); end
    end
    SRC_VALID = 1'b0;
    tick();
    n_checks++;
    if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL und_s1 got=%h exp=%h", dut_vec, exp_vec); end
    SRC_VALID = 1'b1; UND_CLR = 1'b1;
    tick();
    n_checks++;
    if (VGA_DATA !== UND || PIX_X !== 5'd5 || VGA_DE !== 1'b1) begin
      n_fail++; $display("FAIL und_pixel data=%h x=%0d de=%b exp data=%h x=5 de=1", VGA_DATA, PIX_X, VGA_DE, UND);
    end
    n_checks++; if (UNDERFLOW !== 1'b1) begin n_fail++; $display("FAIL und_set_wins got=%b exp=1", UNDERFLOW); end
    UND_CLR = 1'b0;
    repeat (3) begin
      tick();
      n_checks++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL und_hold got=%h exp=%h", dut_vec, exp_vec); end
    end
    n_checks++; if (UNDERFLOW !== 1'b1) begin n_fail++; $display("FAIL und_sticky got=%b exp=1", UNDERFLOW); end
    UND_CLR = 1'b1;
    tick();
    UND_CLR = 1'b0;
    n_checks++; if (UNDERFLOW !== 1'b0) begin n_fail++; $display("FAIL und_clear got=%b exp=0", UNDERFLOW); end
    repeat (600) begin
      SRC_VALID = ($urandom_range(0, 7) != 0);
      UND_CLR   = ($urandom_range(0, 15) == 0);
      tick();
      n_checks++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL und_random p=%0d got=%h exp=%h", p, dut_vec, exp_vec); end
    end
    SRC_VALID = 1'b1; UND_CLR = 1'b0;
  endtask

  task automatic test_en_drop();
    int k;
    for (k = 0; k < 2 * HT * VT && !((p % HT) == HS + HB + 10 && ((p / HT) % VT) == VS + VB + 4); k++) begin
      tick();
      n_checks++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL en_lead p=%0d got=%h exp=%h", p, dut_vec, exp_vec); end
    end
    n_checks++;
    if (k >= 2 * HT * VT) begin n_fail++; $display("FAIL en_target_timeout got=%0d exp<%0d", k, 2 * HT * VT); end
    EN = 1'b0;
    repeat (2) begin
      tick();
      n_checks++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL en_drain got=%h exp=%h", dut_vec, exp_vec); end
    end
    n_checks++;
    if (VGA_DE !== 1'b0 || VGA_HSYNC !== ~HSP) begin
      n_fail++; $display("FAIL en_inactive de=%b hs=%b exp de=0 hs=%b", VGA_DE, VGA_HSYNC, ~HSP);
    end
    repeat (5) begin
      tick();
      n_checks++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL en_off got=%h exp=%h", dut_vec, exp_vec); end
    end
    EN = 1'b1;
    repeat (2) tick();
    n_checks++; if (FRAME_START !== 1'b1) begin n_fail++; $display("FAIL en_restart_fs got=%b exp=1", FRAME_START); end
    repeat (100) begin
      tick();
      n_checks++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL en_after p=%0d got=%h exp=%h", p, dut_vec, exp_vec); end
    end
  endtask

  task automatic test_async_reset();
    int k;
    for (k = 0; k < 2 * HT * VT && !out_m.de; k++) begin
      tick();
      n_checks++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL rst_lead p=%0d got=%h exp=%h", p, dut_vec, exp_vec); end
    end
    #2 SYS_RST = 1'b1;
    #1;
    n_checks++;
    if (get_dut() !== RST_VEC) begin n_fail++; $display("FAIL rst_mid_active got=%h exp=%h", get_dut(), RST_VEC); end
    @(negedge CLK_40M); SYS_RST = 1'b0;
    model_reset();
    repeat (2) tick();
    n_checks++; if (FRAME_START !== 1'b1) begin n_fail++; $display("FAIL rst_restart_fs got=%b exp=1", FRAME_START); end
    repeat (3 * HT * VT / 2) begin
      tick();
      n_checks++;
      if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL rst_after p=%0d got=%h exp=%h", p, dut_vec, exp_vec); end
    end
  endtask

  initial begin
    SYS_RST = 1'b1; EN = 1'b0; SRC_DATA = '0; SRC_VALID = 1'b1; UND_CLR = 1'b0;
    model_reset();
    test_reset();
    test_frame_counts();
    test_underflow();
    test_en_drop();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
